// File: rtl/soc_data_responder_pkg.sv
// soc_data_responder_pkg: data width, config-window offsets and register decode
package soc_data_responder_pkg;
  localparam int XLEN = 32;
  localparam logic [15:0] CONF_TIMER  = 16'h0000;
  localparam logic [15:0] CONF_LED    = 16'h0004;
  localparam logic [15:0] CONF_SWITCH = 16'h0008;
  localparam logic [15:0] CONF_NUM    = 16'h000C;
  typedef enum logic [2:0] {SEL_TIMER, SEL_LED, SEL_SWITCH, SEL_NUM, SEL_NONE} conf_sel_e;
  function automatic conf_sel_e conf_decode(input logic [15:0] off);
    logic [15:0] w;
    w = off & 16'hFFFC;
    return w == CONF_TIMER ? SEL_TIMER : w == CONF_LED ? SEL_LED :
           w == CONF_SWITCH ? SEL_SWITCH : w == CONF_NUM ? SEL_NUM : SEL_NONE;
  endfunction
endpackage

// File: rtl/soc_data_responder_if.sv
// soc_data_responder_if: cpu data-memory port
interface soc_data_responder_if;
  import soc_data_responder_pkg::*;
  logic            en;
  logic [3:0]      wen;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;
  modport master(output en, wen, addr, wdata, input rdata);
  modport slave(input en, wen, addr, wdata, output rdata);
endinterface

// File: rtl/soc_data_responder_sync_2ff.sv
// sync_2ff: two-flop synchronizer, clears to zero in reset
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge clk or negedge reset)
    if (!reset) {q, meta} <= '0;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/soc_data_responder.sv
// soc_data_responder: routes cpu data accesses to the data SRAM or the config register window
module soc_data_responder
  import soc_data_responder_pkg::*;
#(
  parameter logic [XLEN-1:0] CONF_BASE = 32'hBFAF_0000,
  parameter logic [XLEN-1:0] CONF_MASK = 32'hFFFF_0000,
  parameter int              LED_W     = 16,
  parameter int              SW_W      = 8
) (
  input  logic                clk,
  input  logic                reset,
  soc_data_responder_if.slave cpu,
  output logic                data_sram_en,
  output logic [3:0]          data_sram_wen,
  output logic [XLEN-1:0]     data_sram_addr,
  output logic [XLEN-1:0]     data_sram_wdata,
  input  logic [XLEN-1:0]     data_sram_rdata,
  output logic [LED_W-1:0]    led,
  input  logic [SW_W-1:0]     switch,
  output logic [XLEN-1:0]     num_data
);
  logic            hit_conf, wr, sel_conf_q;
  conf_sel_e       sel;
  logic [XLEN-1:0] timer_q, conf_val, conf_rdata_q;
  logic [SW_W-1:0] sw_q;
  function automatic logic [XLEN-1:0] byte_merge(input logic [XLEN-1:0] cur, din, input logic [3:0] be);
    logic [XLEN-1:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? din[8*i +: 8] : cur[8*i +: 8];
    return r;
  endfunction
  sync_2ff #(.W(SW_W)) u_sync (.clk(clk), .reset(reset), .d(switch), .q(sw_q));
  assign hit_conf        = (cpu.addr & CONF_MASK) == CONF_BASE;
  assign sel             = conf_decode(cpu.addr[15:0]);
  assign wr              = cpu.en & hit_conf & |cpu.wen;
  assign data_sram_en    = cpu.en & ~hit_conf;
  assign data_sram_wen   = hit_conf ? 4'b0 : cpu.wen;
  assign data_sram_addr  = cpu.addr;
  assign data_sram_wdata = cpu.wdata;
  assign cpu.rdata       = sel_conf_q ? conf_rdata_q : data_sram_rdata;
  always_comb
    conf_val = sel == SEL_TIMER  ? timer_q :
               sel == SEL_LED    ? XLEN'(led) :
               sel == SEL_SWITCH ? XLEN'(sw_q) :
               sel == SEL_NUM    ? num_data : '0;
  // a software write to the timer replaces that cycle's increment
  always_ff @(posedge clk or negedge reset)
    if (!reset) timer_q <= '0;
    else timer_q <= wr && sel == SEL_TIMER ? byte_merge(timer_q, cpu.wdata, cpu.wen) : timer_q + 1'b1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) led <= '0;
    else if (wr && sel == SEL_LED) led <= LED_W'(byte_merge(XLEN'(led), cpu.wdata, cpu.wen));
  always_ff @(posedge clk or negedge reset)
    if (!reset) num_data <= '0;
    else if (wr && sel == SEL_NUM) num_data <= byte_merge(num_data, cpu.wdata, cpu.wen);
  always_ff @(posedge clk or negedge reset)
    if (!reset) sel_conf_q <= 1'b0;
    else if (cpu.en) sel_conf_q <= hit_conf;
  always_ff @(posedge clk or negedge reset)
    if (!reset) conf_rdata_q <= '0;
    else if (cpu.en && hit_conf) conf_rdata_q <= conf_val;
endmodule

// File: tb/tb_soc_data_responder.sv
// tb_soc_data_responder: random + directed accesses checked against a behavioural model
module tb_soc_data_responder;
  localparam logic [31:0] BASE = 32'hBFAF_0000;
  logic        clk = 1'b0, reset = 1'b0;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata, num_data;
  logic [15:0] led;
  logic [7:0]  switch;
  int n_cmp = 0, n_bad = 0;

  soc_data_responder_if bus();
  soc_data_responder dut (
    .clk(clk), .reset(reset), .cpu(bus),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .led(led), .switch(switch), .num_data(num_data)
  );
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] c, w, input logic [3:0] be);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = w[8*i +: 8];
    return r;
  endfunction

  // environment SRAM: 64 words, 1-cycle read latency, holds output when idle
  logic [31:0] mem [0:63];
  logic [31:0] sram_q = '0;
  assign data_sram_rdata = sram_q;
  always @(posedge clk)
    if (data_sram_en) begin
      if (data_sram_wen == 4'h0) sram_q <= mem[data_sram_addr[7:2]];
      else mem[data_sram_addr[7:2]] <= merge(mem[data_sram_addr[7:2]], data_sram_wdata, data_sram_wen);
    end

  // behavioural model of the register window
  logic [31:0] m_timer, m_num, m_rd;
  logic [15:0] m_led;
  logic [7:0]  m_s1, m_s2;
  logic        m_sel;
  wire         m_hit = bus.addr[31:16] == 16'hBFAF;
  wire  [15:0] m_off = {bus.addr[15:2], 2'b00};
  wire         m_wr  = bus.en && m_hit && bus.wen != 4'h0;
  function automatic logic [31:0] reg_of(input logic [15:0] off);
    case (off)
      16'h0000: return m_timer;
      16'h0004: return {16'h0, m_led};
      16'h0008: return {24'h0, m_s2};
      16'h000C: return m_num;
      default:  return 32'h0;
    endcase
  endfunction
  always @(posedge clk or negedge reset)
    if (!reset) begin
      m_timer <= 0; m_num <= 0; m_rd <= 0; m_led <= 0; m_s1 <= 0; m_s2 <= 0; m_sel <= 0;
    end else begin
      m_timer <= (m_wr && m_off == 16'h0) ? merge(m_timer, bus.wdata, bus.wen) : m_timer + 1;
      if (m_wr && m_off == 16'h4) m_led <= 16'(merge({16'h0, m_led}, bus.wdata, bus.wen));
      if (m_wr && m_off == 16'hC) m_num <= merge(m_num, bus.wdata, bus.wen);
      m_s1 <= switch;
      m_s2 <= m_s1;
      if (bus.en) begin
        m_sel <= m_hit;
        if (m_hit) m_rd <= reg_of(m_off);
      end
    end

  task automatic chk(input string n, input logic [31:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (reset) begin
      chk("rdata", bus.rdata, m_sel ? m_rd : sram_q);
      chk("led", {16'h0, led}, {16'h0, m_led});
      chk("num", num_data, m_num);
      chk("sram_en", {31'h0, data_sram_en}, {31'h0, bus.en && !m_hit});
      chk("sram_wen", {28'h0, data_sram_wen}, {28'h0, m_hit ? 4'h0 : bus.wen});
      chk("sram_addr", data_sram_addr, bus.addr);
      chk("sram_wdata", data_sram_wdata, bus.wdata);
    end

  task automatic op(input logic en, input logic [3:0] wen, input logic [31:0] a, wd);
    bus.en = en; bus.wen = wen; bus.addr = a; bus.wdata = wd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] wrap_exp [4];
    logic [31:0] a;
    wrap_exp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[4] = 32'hDEAD_BEEF;
    bus.en = 0; bus.wen = 0; bus.addr = 0; bus.wdata = 0; switch = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_led", {16'h0, led}, 32'h0);
    chk("rst_num", num_data, 32'h0);
    chk("rst_rdata", bus.rdata, sram_q);
    reset = 1;
    op(1, 4'h0, BASE, 0);         chk("timer_first", bus.rdata, 32'h0);
    op(1, 4'h0, BASE, 0);         chk("timer_second", bus.rdata, 32'h1);
    op(1, 4'h0, BASE + 4, 0);     chk("led_rst_read", bus.rdata, 32'h0);
    op(1, 4'hF, BASE + 4, 32'h0000_A5A5); chk("led_write", {16'h0, led}, 32'h0000_A5A5);
    op(1, 4'h0, BASE + 4, 0);     chk("led_readback", bus.rdata, 32'h0000_A5A5);
    op(1, 4'hF, BASE, 32'h1234);
    op(1, 4'h1, BASE, 32'hFF);
    op(1, 4'h0, BASE, 0);         chk("timer_merge", bus.rdata, 32'h12FF);
    op(1, 4'h0, BASE, 0);         chk("timer_after_merge", bus.rdata, 32'h1300);
    op(1, 4'hF, BASE, 32'hFFFF_FFFE);
    for (int i = 0; i < 4; i++) begin
      op(1, 4'h0, BASE, 0);
      chk("timer_wrap", bus.rdata, wrap_exp[i]);
    end
    switch = 8'h3C;
    op(0, 4'h0, 0, 0);
    op(0, 4'h0, 0, 0);
    op(1, 4'h0, BASE + 8, 0);     chk("switch_read", bus.rdata, 32'h3C);
    op(1, 4'hF, BASE + 8, 32'hFFFF_FFFF);
    op(1, 4'h0, BASE + 8, 0);     chk("switch_ro", bus.rdata, 32'h3C);
    op(1, 4'hF, BASE + 12, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      op(1, 4'h0, 32'h8000_0010, 0); chk("alt_ram", bus.rdata, 32'hDEAD_BEEF);
      op(1, 4'h0, BASE + 12, 0);     chk("alt_conf", bus.rdata, 32'h1234_5678);
    end
    op(0, 4'h0, 32'h8000_0010, 0); chk("hold", bus.rdata, 32'h1234_5678);
    op(1, 4'hF, BASE + 16'h20, 32'h5555_5555);
    op(1, 4'h0, BASE + 16'h20, 0); chk("unmapped", bus.rdata, 32'h0);
    op(1, 4'h0, BASE + 16'h0E, 0); chk("unaligned", bus.rdata, 32'h1234_5678);
    bus.en = 1; bus.wen = 0; bus.addr = BASE + 4; bus.wdata = 0;
    #2 reset = 0;
    #1;
    chk("midrst_rdata", bus.rdata, sram_q);
    chk("midrst_led", {16'h0, led}, 32'h0);
    chk("midrst_num", num_data, 32'h0);
    @(posedge clk);
    #1 reset = 1;
    op(1, 4'h0, BASE, 0);         chk("timer_after_rst", bus.rdata, 32'h0);
    for (int i = 0; i < 600; i++) begin
      case ($urandom % 3)
        0:       a = 32'h8000_0000 | ($urandom & 32'hFF);
        1:       a = BASE | ($urandom % 40);
        default: a = (BASE ^ 32'h0001_0000) | ($urandom % 16);
      endcase
      if ($urandom % 8 == 0) switch = 8'($urandom);
      op($urandom % 4 != 0, ($urandom % 2) ? 4'h0 : 4'($urandom), a, $urandom);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
